// File: rtl/alu_pkg.sv
// Shared ALU opcode map and the MAC sequencer state encoding.
package alu_pkg;

    // Integer opcodes
    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_MUL  = 4'd2;
    localparam logic [3:0] ALU_OP_DIV  = 4'd3;
    localparam logic [3:0] ALU_OP_AND  = 4'd4;
    localparam logic [3:0] ALU_OP_OR   = 4'd5;
    localparam logic [3:0] ALU_OP_XOR  = 4'd6;
    localparam logic [3:0] ALU_OP_SHL  = 4'd7;
    // Floating-point opcodes
    localparam logic [3:0] ALU_OP_FADD = 4'd8;
    localparam logic [3:0] ALU_OP_FSUB = 4'd9;
    localparam logic [3:0] ALU_OP_FMUL = 4'd10;
    // Idle opcode: ALU output is don't-care
    localparam logic [3:0] ALU_OP_NOP  = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_MUL,
        ST_ADD,
        ST_DONE
    } mac_state_t;

endpackage

// File: rtl/alu_mac_sequencer.sv
// MAC sequencer: feeds (pixel, weight) pairs through an external ALU as
// MUL then ADD, accumulating one dot product per start.
// Optional feature macro: MAC_SEQ_BIAS_EN adds a bias input that seeds the accumulator.
module alu_mac_sequencer
    import alu_pkg::*;
#(
    parameter int DW       = 16,
    parameter int MAX_TAPS = 9,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_taps,
`ifdef MAC_SEQ_BIAS_EN
    input  logic [DW-1:0]    bias,
`endif
    output logic             busy,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [DW-1:0]    op_pixel,
    input  logic [DW-1:0]    op_weight,
    output logic [3:0]       alu_op,
    output logic [DW-1:0]    alu_a,
    output logic [DW-1:0]    alu_b,
    input  logic [DW-1:0]    alu_result,
    input  logic             alu_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic             out_ovf
);

    mac_state_t       state, next_state;
    logic [CNT_W-1:0] n_taps;
    logic [CNT_W-1:0] n_sel;
    logic [CNT_W-1:0] tap_cnt;
    logic [DW-1:0]    acc;
    logic [DW-1:0]    acc_init;
    logic             ovf;
    logic             last_tap;

    assign n_sel    = (num_taps > CNT_W'(MAX_TAPS)) ? CNT_W'(MAX_TAPS) : num_taps;
    assign last_tap = ((tap_cnt + CNT_W'(1)) == n_taps);

`ifdef MAC_SEQ_BIAS_EN
    assign acc_init = bias;
`else
    assign acc_init = '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = (n_sel == '0) ? ST_DONE : ST_FETCH;
            ST_FETCH: if (op_valid) next_state = ST_MUL;
            ST_MUL:   next_state = ST_ADD;
            ST_ADD:   next_state = last_tap ? ST_DONE : ST_FETCH;
            ST_DONE:  if (out_ready) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Datapath: ALU operand registers, accumulator, overflow flag, tap counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_taps  <= '0;
            tap_cnt <= '0;
            acc     <= '0;
            ovf     <= 1'b0;
            alu_op  <= ALU_OP_NOP;
            alu_a   <= '0;
            alu_b   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_taps  <= n_sel;
                        tap_cnt <= '0;
                        acc     <= acc_init;
                        ovf     <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (op_valid) begin
                        alu_op <= ALU_OP_MUL;
                        alu_a  <= op_pixel;
                        alu_b  <= op_weight;
                    end
                end
                ST_MUL: begin
                    // Product goes straight back into the ALU as the ADD operand
                    ovf    <= ovf | alu_carry;
                    alu_op <= ALU_OP_ADD;
                    alu_a  <= acc;
                    alu_b  <= alu_result;
                end
                ST_ADD: begin
                    acc     <= alu_result;
                    ovf     <= ovf | alu_carry;
                    tap_cnt <= tap_cnt + CNT_W'(1);
                    alu_op  <= ALU_OP_NOP;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign op_ready  = (state == ST_FETCH);
    assign out_valid = (state == ST_DONE);
    assign out_data  = acc;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_alu_mac_sequencer.sv
// Randomized self-checking bench for alu_mac_sequencer with a behavioural ALU
// and a dot-product reference model.
module tb_alu_mac_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  num_taps;
    logic [15:0] bias;
    logic        busy;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_pixel;
    logic [15:0] op_weight;
    logic [3:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        alu_carry;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [15:0] pix [16];
    logic [15:0] wt  [16];

    always #5 clk = ~clk;

    alu_mac_sequencer #(.DW(16), .MAX_TAPS(9), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_taps(num_taps),
`ifdef MAC_SEQ_BIAS_EN
        .bias(bias),
`endif
        .busy(busy), .op_valid(op_valid), .op_ready(op_ready),
        .op_pixel(op_pixel), .op_weight(op_weight),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    // Behavioural integer ALU: carry = unsigned overflow of the 16-bit result
    logic [31:0] prod;
    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        prod       = '0;
        case (alu_op)
            ALU_OP_ADD: {alu_carry, alu_result} = 17'(alu_a) + 17'(alu_b);
            ALU_OP_MUL: begin
                prod       = 32'(alu_a) * 32'(alu_b);
                alu_result = prod[15:0];
                alu_carry  = |prod[31:16];
            end
            default: ;
        endcase
    end

    task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Dot product from the arithmetic rules: sum of products mod 2^16,
    // overflow if any product or any partial sum leaves 16 bits.
    function automatic void model(input int n, input int unsigned b,
                                  output int unsigned data, output bit ovf);
        longint unsigned acc, p;
        int neff;
        neff = (n > 9) ? 9 : n;
        acc  = b;
        ovf  = 1'b0;
        for (int i = 0; i < neff; i++) begin
            p = longint'(pix[i]) * longint'(wt[i]);
            if (p >= 65536) ovf = 1'b1;
            p   = p % 65536;
            acc = acc + p;
            if (acc >= 65536) ovf = 1'b1;
            acc = acc % 65536;
        end
        data = int'(acc);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".busy"},  busy, 0);
        check_eq({tag, ".rdy"},   op_ready, 0);
        check_eq({tag, ".vld"},   out_valid, 0);
        check_eq({tag, ".data"},  out_data, 0);
        check_eq({tag, ".ovf"},   out_ovf, 0);
        check_eq({tag, ".op"},    alu_op, 15);
        check_eq({tag, ".a"},     alu_a, 0);
        check_eq({tag, ".b"},     alu_b, 0);
    endtask

    // One full dot product: gap = idle cycles before each operand,
    // hold = cycles out_ready stays low in DONE, poke = pulse start while busy.
    task automatic run_dot(input int n, input int gap, input int hold, input bit poke, input string tag);
        int unsigned exp_d;
        bit exp_o;
        int neff, cyc, idx, g;
        bit hs;
        neff = (n > 9) ? 9 : n;
        model(n, int'(bias), exp_d, exp_o);
        @(negedge clk);
        num_taps = 4'(n);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; idx = 0; g = gap;
        while (!out_valid && cyc < 400) begin
            if (op_ready && g == 0) begin
                op_valid  = 1'b1;
                op_pixel  = pix[idx];
                op_weight = wt[idx];
            end else begin
                op_valid  = 1'b0;
                op_pixel  = 16'($urandom);
                op_weight = 16'($urandom);
            end
            if (op_ready && g > 0) g--;
            start    = poke ? ~start : 1'b0;
            num_taps = 4'($urandom);
            hs = op_valid && op_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) begin idx++; g = gap; end
        end
        op_valid = 1'b0;
        start    = 1'b0;
        check_eq({tag, ".valid"}, out_valid, 1);
        if (gap == 0) check_eq({tag, ".lat"}, cyc, 3 * neff + 1);
        check_eq({tag, ".taps"}, idx, neff);
        check_eq({tag, ".data"}, out_data, exp_d);
        check_eq({tag, ".ovf"},  out_ovf, exp_o);
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check_eq({tag, ".hold_v"}, out_valid, 1);
            check_eq({tag, ".hold_d"}, out_data, exp_d);
        end
        out_ready = 1'b1;
        start     = poke;
        num_taps  = 4'd3;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        check_eq({tag, ".idle"}, busy, 0);
        check_eq({tag, ".vld_drop"}, out_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; num_taps = '0; bias = '0;
        op_valid = 1'b0; op_pixel = '0; op_weight = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Basic three-tap dot product: 6 + 20 + 7
        pix[0] = 16'd2; wt[0] = 16'd3;
        pix[1] = 16'd4; wt[1] = 16'd5;
        pix[2] = 16'd1; wt[2] = 16'd7;
        run_dot(3, 0, 0, 1'b0, "t1");
        check_eq("t1.sum33", out_data, 33);

        // Product overflow sets the sticky flag
        pix[0] = 16'h0100; wt[0] = 16'h0100;
        pix[1] = 16'd1;    wt[1] = 16'd1;
        run_dot(2, 0, 0, 1'b0, "t2");

        // Zero taps, then clamped tap count
        run_dot(0, 0, 0, 1'b0, "t3a");
        for (int i = 0; i < 16; i++) begin pix[i] = 16'd1; wt[i] = 16'd1; end
        run_dot(12, 0, 0, 1'b0, "t3b");

        // Operand gaps, back-pressure in DONE, start pulses while busy
        for (int i = 0; i < 16; i++) begin pix[i] = 16'($urandom_range(0, 300)); wt[i] = 16'($urandom_range(0, 300)); end
        run_dot(4, 2, 5, 1'b1, "t4");

        // Reset during ADD of the second tap
        @(negedge clk);
        num_taps = 4'd3; start = 1'b1;
        op_valid = 1'b1; op_pixel = 16'd9; op_weight = 16'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("t5.in_add", alu_op, ALU_OP_ADD);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; op_valid = 1'b0;
        check_reset_outputs("t5.rst");
        pix[0] = 16'd10; wt[0] = 16'd11;
        pix[1] = 16'd12; wt[1] = 16'd13;
        run_dot(2, 0, 1, 1'b0, "t5.clean");

`ifdef MAC_SEQ_BIAS_EN
        bias = 16'd100;
        pix[0] = 16'd3; wt[0] = 16'd4;
        run_dot(1, 0, 0, 1'b0, "t6");
        check_eq("t6.sum112", out_data, 112);
        run_dot(0, 0, 0, 1'b0, "t6.zero");
`endif

        // Randomized dot products, some with wide operands to hit wrap
        for (int t = 0; t < 25; t++) begin
            bit wide;
            wide = 1'($urandom);
            for (int i = 0; i < 16; i++) begin
                pix[i] = wide ? 16'($urandom) : 16'($urandom_range(0, 255));
                wt[i]  = wide ? 16'($urandom) : 16'($urandom_range(0, 255));
            end
`ifdef MAC_SEQ_BIAS_EN
            bias = 16'($urandom);
`endif
            run_dot(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)), 1'($urandom), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
